// File: rtl/gf180mcu_nand3_bist_ctrl.sv
// gf180mcu_nand3_bist_ctrl
// Built-in self-test sequencer for a single NAND3 cell (A1/A2/A3 -> ZN).
// Each of the 8 input vectors is held for SETTLE_CYCLES cycles and then
// sampled for one cycle against the ideal NAND3 response. The whole
// 8-vector pass is repeated LOOPS times. The results are a pass flag, a
// saturating error count and the first failing vector.
// Optional build macro: BIST_GRAY_ORDER_EN. When it is defined, vectors are
// applied in Gray-code order so that one input toggles per step. When it is
// undefined, vectors are applied in plain binary order.
module gf180mcu_nand3_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_CNT_W     = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 PASS,
   output logic                 A1,
   output logic                 A2,
   output logic                 A3,
   input  logic                 ZN,
   output logic [ERR_CNT_W-1:0] ERR_CNT,
   output logic [2:0]           FAIL_VEC,
   output logic                 FAIL_VALID
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FIN    = 2'd3
   } state_t;

   localparam logic [7:0]           SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0]           LOOP_LAST   = 4'(LOOPS - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

   state_t      state_r;
   logic [7:0]  settle_cnt_r;
   logic [2:0]  idx_r;
   logic [3:0]  loop_r;
   logic [2:0]  vec_r;

   logic        expected_s;
   logic        mismatch_s;
   logic        last_vec_s;
   logic [2:0]  idx_next_s;

   // Map a vector index to the value applied on {A3,A2,A1}.
   function automatic logic [2:0] seq_vec(input logic [2:0] i);
`ifdef BIST_GRAY_ORDER_EN
      return i ^ {1'b0, i[2:1]};
`else
      return i;
`endif
   endfunction

   assign A1 = vec_r[0];
   assign A2 = vec_r[1];
   assign A3 = vec_r[2];

   // Ideal response, the mismatch decision (X/Z on ZN counts as a fail), and the next-index decode.
   always_comb begin
      expected_s = ~(vec_r[0] & vec_r[1] & vec_r[2]);
      mismatch_s = (ZN !== expected_s) ? 1'b1 : 1'b0;
      last_vec_s = ((idx_r == 3'd7) && (loop_r == LOOP_LAST)) ? 1'b1 : 1'b0;
      idx_next_s = idx_r + 3'd1;
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= 8'd0;
         idx_r        <= 3'd0;
         loop_r       <= 4'd0;
         vec_r        <= 3'd0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         PASS         <= 1'b0;
         ERR_CNT      <= {ERR_CNT_W{1'b0}};
         FAIL_VEC     <= 3'd0;
         FAIL_VALID   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               DONE  <= 1'b0;
               vec_r <= 3'd0;
               if (START) begin
                  ERR_CNT      <= {ERR_CNT_W{1'b0}};
                  FAIL_VEC     <= 3'd0;
                  FAIL_VALID   <= 1'b0;
                  PASS         <= 1'b0;
                  idx_r        <= 3'd0;
                  loop_r       <= 4'd0;
                  vec_r        <= seq_vec(3'd0);
                  settle_cnt_r <= SETTLE_LOAD;
                  BUSY         <= 1'b1;
                  state_r      <= ST_SETTLE;
               end else begin
                  BUSY    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_r == 8'd0) begin
                  state_r <= ST_SAMPLE;
               end else begin
                  settle_cnt_r <= settle_cnt_r - 8'd1;
               end
            end
            ST_SAMPLE: begin
               if (mismatch_s) begin
                  if (ERR_CNT != ERR_MAX) begin
                     ERR_CNT <= ERR_CNT + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                  end
                  if (!FAIL_VALID) begin
                     FAIL_VEC   <= vec_r;
                     FAIL_VALID <= 1'b1;
                  end
               end
               if (last_vec_s) begin
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
                  PASS    <= ((ERR_CNT == {ERR_CNT_W{1'b0}}) && !mismatch_s) ? 1'b1 : 1'b0;
                  vec_r   <= 3'd0;
                  state_r <= ST_FIN;
               end else begin
                  idx_r <= idx_next_s;
                  if (idx_r == 3'd7) begin
                     loop_r <= loop_r + 4'd1;
                  end
                  vec_r        <= seq_vec(idx_next_s);
                  settle_cnt_r <= SETTLE_LOAD;
                  state_r      <= ST_SETTLE;
               end
            end
            ST_FIN: begin
               DONE    <= 1'b0;
               BUSY    <= 1'b0;
               vec_r   <= 3'd0;
               idx_r   <= 3'd0;
               loop_r  <= 4'd0;
               state_r <= ST_IDLE;
            end
            default: begin
               BUSY    <= 1'b0;
               DONE    <= 1'b0;
               vec_r   <= 3'd0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf180mcu_nand3_bist_ctrl.sv
// Self-checking bench for gf180mcu_nand3_bist_ctrl. A run-relative cycle
// model predicts every output on every cycle. Literal expectations pin the
// run latency and the results of the stuck-at runs.
module tb_gf180mcu_nand3_bist_ctrl;

   localparam int S = 2;
   localparam int L = 2;
   localparam int W = 2;
   localparam int T = 8 * L * (S + 1);   // cycles from first valid vector to FIN

   logic         clk = 1'b0;
   logic         rst, start, zn;
   logic         busy, done, pass, a1, a2, a3, fail_valid;
   logic [W-1:0] err_cnt;
   logic [2:0]   fail_vec;

   always #5 clk = ~clk;

   gf180mcu_nand3_bist_ctrl #(.SETTLE_CYCLES(S), .LOOPS(L), .ERR_CNT_W(W)) dut (
      .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done), .PASS(pass),
      .A1(a1), .A2(a2), .A3(a3), .ZN(zn), .ERR_CNT(err_cnt), .FAIL_VEC(fail_vec),
      .FAIL_VALID(fail_valid)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int mode     = 0;   // 0 ideal cell, 1 stuck-at-1, 2 stuck-at-0, 3 random ZN

   // Model state: m_k = -1 idle, 0..T-1 inside run, T = FIN cycle
   bit       m_known = 1'b0;
   int       m_k     = -1;
   int       m_err   = 0;
   int       m_fv    = 0;
   bit       m_fvalid = 1'b0;
   bit       m_pass  = 1'b0;

   bit       done_seen;
   int       done_cnt, done_cyc;
   int       r_err, r_fv, r_fvalid, r_pass;

   function automatic int seq_of(input int j);
`ifdef BIST_GRAY_ORDER_EN
      return j ^ (j >> 1);
`else
      return j;
`endif
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
   endtask

   // One clock cycle: compare, drive inputs, advance the model, wait for the edge.
   task automatic step(input logic r, input logic s);
      int  e_busy, e_done, e_a, e_err, a_cur;
      logic z, expz;
      @(negedge clk);
      e_busy = (m_k >= 0 && m_k < T) ? 1 : 0;
      e_done = (m_k == T) ? 1 : 0;
      e_a    = e_busy ? seq_of((m_k / (S + 1)) % 8) : 0;
      e_err  = (m_err > (2**W - 1)) ? (2**W - 1) : m_err;
      if (m_known) begin
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("a_vec", {a3, a2, a1}, e_a);
         check("err_cnt", err_cnt, e_err);
         check("fail_valid", fail_valid, m_fvalid);
         check("fail_vec", fail_vec, m_fv);
         check("pass", pass, m_pass);
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (!done_seen) begin
            done_seen = 1'b1; done_cyc = cyc;
            r_err = err_cnt; r_fv = fail_vec; r_fvalid = fail_valid; r_pass = pass;
         end
      end
      case (mode)
         0:       z = (e_a == 7) ? 1'b0 : 1'b1;
         1:       z = 1'b1;
         2:       z = 1'b0;
         default: z = 1'($urandom_range(0, 1));
      endcase
      rst = r; start = s; zn = z;
      if (r) begin
         m_known = 1'b1; m_k = -1; m_err = 0; m_fv = 0; m_fvalid = 1'b0; m_pass = 1'b0;
      end else if (m_known) begin
         if (m_k >= 0 && m_k < T) begin
            if (m_k % (S + 1) == S) begin
               a_cur = seq_of((m_k / (S + 1)) % 8);
               expz  = (a_cur == 7) ? 1'b0 : 1'b1;
               if (z !== expz) begin
                  m_err++;
                  if (!m_fvalid) begin m_fvalid = 1'b1; m_fv = a_cur; end
               end
            end
            m_k++;
            if (m_k == T) m_pass = (m_err == 0);
         end else if (m_k == T) begin
            m_k = -1;
         end else if (s) begin
            m_k = 0; m_err = 0; m_fv = 0; m_fvalid = 1'b0; m_pass = 1'b0;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   // Single START pulse, optional START noise while busy, then literal result checks.
   task automatic do_run(input int md, input bit noise);
      int c0;
      mode = md; done_seen = 1'b0; done_cnt = 0; c0 = cyc;
      step(1'b0, 1'b1);
      for (int i = 0; i < 51; i++) begin
         step(1'b0, (noise && m_k >= 0 && m_k < T) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      check("done_latency", done_seen ? (done_cyc - c0) : -1, 49);
      check("done_pulses", done_cnt, 1);
      if (md == 0) begin
         check("ideal_pass", r_pass, 1);
         check("ideal_err", r_err, 0);
         check("ideal_fvalid", r_fvalid, 0);
      end else if (md == 1) begin
         check("sa1_err", r_err, 2);
         check("sa1_fvec", r_fv, 7);
         check("sa1_fvalid", r_fvalid, 1);
         check("sa1_pass", r_pass, 0);
      end else if (md == 2) begin
         check("sa0_err_sat", r_err, 3);
         check("sa0_fvec", r_fv, 0);
         check("sa0_pass", r_pass, 0);
      end
   endtask

   initial begin
      int c0;
      rst = 1'b1; start = 1'b0; zn = 1'b0; mode = 3;
      repeat (2) step(1'b1, 1'($urandom_range(0, 1)));
      mode = 0;
      repeat (4) step(1'b0, 1'b0);
      #1;
      check("reset_outputs", {busy, done, pass, a3, a2, a1, err_cnt, fail_vec, fail_valid}, 0);

      do_run(0, 1'b1);
      do_run(1, 1'b1);
      do_run(2, 1'b0);
      do_run(0, 1'b0);

      // Abort mid-run: RST in cycle 10 of the run
      mode = 1; done_seen = 1'b0; done_cnt = 0;
      step(1'b0, 1'b1);
      repeat (9) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      #1;
      check("abort_busy", busy, 0);
      check("abort_a", {a3, a2, a1}, 0);
      check("abort_err", err_cnt, 0);
      repeat (45) step(1'b0, 1'b0);
      check("abort_no_done", done_cnt, 0);
      do_run(0, 1'b1);

      repeat (4) do_run(3, 1'b1);

      // START held high: back-to-back runs
      mode = 0; done_seen = 1'b0; done_cnt = 0; c0 = cyc;
      repeat (110) step(1'b0, 1'b1);
      check("held_done_count", done_cnt, 2);
      check("held_first_done", done_cyc - c0, 49);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
